// File: rtl/aes_spi_pkg.sv
// Shared types, widths and helpers for the AES SPI master and its sub-blocks.
package aes_spi_pkg;

  localparam int unsigned BLK_BITS = 128;
  localparam int unsigned CNT_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_MSG = 3'd1,
    ST_SEND_KEY = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RECV     = 3'd4
  } state_t;

  function automatic int unsigned key_bits(input int unsigned nk);
    return 32 * nk;
  endfunction

endpackage

// File: rtl/aes_spi_master_if.sv
// Request/response and serial-line bundle between the AES SPI master and its user/slave.
interface aes_spi_master_if
  import aes_spi_pkg::*;
#(
  parameter int unsigned NK = 4
) ();

  logic                     start;
  logic [BLK_BITS-1:0]      msg;
  logic [key_bits(NK)-1:0]  key;
  logic                     mode_in;
  logic                     mode;
  logic                     SIMO;
  logic                     SOMI;
  logic                     busy;
  logic                     done;
  logic [BLK_BITS-1:0]      result;

  modport master (
    input  start, msg, key, mode_in, SOMI,
    output mode, SIMO, busy, done, result
  );

  modport slave (
    output start, msg, key, mode_in, SOMI,
    input  mode, SIMO, busy, done, result
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Right-shifting register: parallel load, serial in at MSB, low QW bits exposed (q[0] is the serial out).
module spi_shift_reg #(
  parameter int unsigned W  = 8,
  parameter int unsigned QW = W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  din,
  input  logic          sin,
  output logic [QW-1:0] q
);

  logic [W-1:0] r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (load) begin
      r <= din;
    end else if (shift) begin
      r <= {sin, r[W-1:1]};
    end
  end

  assign q = r[QW-1:0];

endmodule

// File: rtl/aes_spi_master.sv
// Serialises block+key to the AES slave, waits out its processing time, then deserialises the result.
// Optional chip select output cs_n is enabled by defining AES_SPI_CS_EN.
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int unsigned NK          = 4,
  parameter int unsigned NR          = 10,
  parameter int unsigned WAIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  aes_spi_master_if.master  bus
`ifdef AES_SPI_CS_EN
  ,
  output logic              cs_n
`endif
);

  localparam int unsigned KB   = key_bits(NK);
  localparam int unsigned TX_W = BLK_BITS + KB;

  localparam logic [CNT_W-1:0] MSG_LAST  = CNT_W'(BLK_BITS - 1);
  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KB - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  // First result bit is taken on the WAIT exit edge, so RECV covers the remaining 127.
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(BLK_BITS - 2);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_spi_master: NK must be 4, 6 or 8");
  end
  if (NR != NK + 6) begin : g_bad_nr
    $error("aes_spi_master: NR does not pair with NK");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > (1 << CNT_W)) begin : g_bad_wait
    $error("aes_spi_master: WAIT_CYCLES out of range");
  end

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                busy_q;
  logic                done_q;
  logic                mode_q;
  logic [0:0]          tx_lsb;
  logic [BLK_BITS-1:0] rx_q;

  logic accept_c;
  logic tx_shift_c;
  logic rx_shift_c;
  logic recv_end_c;

  assign accept_c   = (state == ST_IDLE) && bus.start;
  assign tx_shift_c = (state == ST_SEND_MSG) || (state == ST_SEND_KEY);
  assign rx_shift_c = ((state == ST_WAIT) && (cnt == WAIT_LAST)) || (state == ST_RECV);
  assign recv_end_c = (state == ST_RECV) && (cnt == RECV_LAST);

  // TX drains to all-zero after the key phase, which keeps SIMO low in WAIT/RECV/IDLE.
  spi_shift_reg #(.W(TX_W), .QW(1)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_c),
    .shift (tx_shift_c),
    .din   ({bus.key, bus.msg}),
    .sin   (1'b0),
    .q     (tx_lsb)
  );

  spi_shift_reg #(.W(BLK_BITS), .QW(BLK_BITS)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (rx_shift_c),
    .din   ('0),
    .sin   (bus.SOMI),
    .q     (rx_q)
  );

  // Transaction sequencer; counter restarts at every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt    <= cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.start) begin
            state  <= ST_SEND_MSG;
            busy_q <= 1'b1;
            mode_q <= bus.mode_in;
          end
        end
        ST_SEND_MSG: begin
          if (cnt == MSG_LAST) begin
            state <= ST_SEND_KEY;
            cnt   <= '0;
          end
        end
        ST_SEND_KEY: begin
          if (cnt == KEY_LAST) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= ST_RECV;
            cnt   <= '0;
          end
        end
        ST_RECV: begin
          if (cnt == RECV_LAST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_SPI_CS_EN
  // Select frames the whole transaction, from accept to the done-raising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n <= 1'b1;
    end else if (accept_c) begin
      cs_n <= 1'b0;
    end else if (recv_end_c) begin
      cs_n <= 1'b1;
    end
  end
`endif

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.mode   = mode_q;
  assign bus.SIMO   = tx_lsb[0];
  assign bus.result = rx_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed + randomized bench for aes_spi_master (NK=4 and NK=8 instances, behavioural slave model).
module tb_aes_spi_master;

  localparam int WAITC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic         mode_r;
  logic         somi;
  logic         sel;
  logic [127:0] msg_r;
  logic [255:0] key_r;

  int total = 0;
  int bad   = 0;

  aes_spi_master_if #(.NK(4)) if4 ();
  aes_spi_master_if #(.NK(8)) if8 ();

  assign if4.start   = start & ~sel;
  assign if4.msg     = msg_r;
  assign if4.key     = key_r[127:0];
  assign if4.mode_in = mode_r;
  assign if4.SOMI    = somi;
  assign if8.start   = start & sel;
  assign if8.msg     = msg_r;
  assign if8.key     = key_r;
  assign if8.mode_in = mode_r;
  assign if8.SOMI    = somi;

`ifdef AES_SPI_CS_EN
  logic cs4, cs8, cs_o;
  assign cs_o = sel ? cs8 : cs4;
`endif

  aes_spi_master #(.NK(4), .NR(10), .WAIT_CYCLES(WAITC)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.master)
`ifdef AES_SPI_CS_EN
    , .cs_n (cs4)
`endif
  );

  aes_spi_master #(.NK(8), .NR(14), .WAIT_CYCLES(WAITC)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.master)
`ifdef AES_SPI_CS_EN
    , .cs_n (cs8)
`endif
  );

  logic         busy_o, done_o, simo_o, mode_o;
  logic [127:0] result_o;
  assign busy_o   = sel ? if8.busy   : if4.busy;
  assign done_o   = sel ? if8.done   : if4.done;
  assign simo_o   = sel ? if8.SIMO   : if4.SIMO;
  assign mode_o   = sel ? if8.mode   : if4.mode;
  assign result_o = sel ? if8.result : if4.result;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction. Sample n is the negedge after edge E0+n-1 (E0 = accept edge).
  // The slave model records SIMO as a bit stream, then returns either the captured
  // block (echo) or a fixed pattern, one bit per clk starting 128+32*NK+WAIT clks after accept.
  task automatic txn(input logic [127:0] m, input logic [255:0] k, input logic md,
                     input bit echo, input logic [127:0] pat,
                     input int intr_at, input int rst_at, input bit hold);
    int kb, len, lat, n, simo_err, busy_err, mode_err, cs_err;
    logic [127:0] cap_m, resp;
    logic [255:0] cap_k, k_exp;
    bit seen, aborted;
    kb    = sel ? 256 : 128;
    len   = 128 + kb;
    lat   = len + WAITC + 128;
    k_exp = sel ? k : {128'd0, k[127:0]};
    cap_m = '0; cap_k = '0; resp = pat;
    simo_err = 0; busy_err = 0; mode_err = 0; cs_err = 0;
    seen = 1'b0; aborted = 1'b0; n = 0;
    start = 1'b1; msg_r = m; key_r = k; mode_r = md;
    while (!seen && !aborted && n < lat + 8) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("accept_busy", 256'(busy_o), 256'(1'b1));
        chk("accept_mode", 256'(mode_o), 256'(md));
        chk("accept_no_done", 256'(done_o), 256'(1'b0));
        start = hold;
      end
      if (intr_at > 0 && n == intr_at) begin
        start = 1'b1; msg_r = ~m; key_r = ~k; mode_r = ~md;
      end
      if (intr_at > 0 && n == intr_at + 1) start = hold;
      if (n - 1 < 128)      cap_m[n-1] = simo_o;
      else if (n - 1 < len) cap_k[n-1-128] = simo_o;
      else if (simo_o !== 1'b0) simo_err++;
      if (n <= 4)   chk("simo_msg_bit", 256'(simo_o), 256'(m[n-1]));
      if (n == 129) chk("simo_key_bit0", 256'(simo_o), 256'(k[0]));
      if (n == len && echo) resp = cap_m;
      if (n >= len + WAITC && n < len + WAITC + 128) somi = resp[n-len-WAITC];
      else somi = 1'($urandom);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        chk("done_latency", 256'(n), 256'(lat));
        chk("result", 256'(result_o), 256'(resp));
        chk("done_busy_low", 256'(busy_o), 256'(1'b0));
        chk("captured_msg", 256'(cap_m), 256'(m));
        chk("captured_key", cap_k, k_exp);
`ifdef AES_SPI_CS_EN
        chk("cs_high_at_done", 256'(cs_o), 256'(1'b1));
        chk("cs_low_window", 256'(n), 256'(lat));
`endif
      end else begin
        if (busy_o !== 1'b1) busy_err++;
        if (mode_o !== md)   mode_err++;
`ifdef AES_SPI_CS_EN
        if (cs_o !== 1'b0)   cs_err++;
`endif
      end
      if (rst_at >= 0 && n == len + WAITC + rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 256'(busy_o), 256'(1'b0));
        chk("rst_done", 256'(done_o), 256'(1'b0));
        chk("rst_result", 256'(result_o), 256'(0));
        chk("rst_simo", 256'(simo_o), 256'(1'b0));
`ifdef AES_SPI_CS_EN
        chk("rst_cs", 256'(cs_o), 256'(1'b1));
`endif
        rst = 1'b0;
        aborted = 1'b1;
      end
    end
    chk("simo_zero_after_key", 256'(simo_err), 256'(0));
    chk("busy_held", 256'(busy_err), 256'(0));
    chk("mode_stable", 256'(mode_err), 256'(0));
`ifdef AES_SPI_CS_EN
    chk("cs_low_while_busy", 256'(cs_err), 256'(0));
`endif
    if (!aborted) begin
      chk("done_seen", 256'(seen), 256'(1'b1));
      if (!hold) begin
        @(negedge clk);
        chk("done_one_cycle", 256'(done_o), 256'(1'b0));
        chk("idle_busy", 256'(busy_o), 256'(1'b0));
        chk("result_held", 256'(result_o), 256'(resp));
        chk("mode_kept", 256'(mode_o), 256'(md));
        chk("idle_simo", 256'(simo_o), 256'(1'b0));
`ifdef AES_SPI_CS_EN
        chk("idle_cs", 256'(cs_o), 256'(1'b1));
`endif
      end
    end
  endtask

  initial begin
    logic [127:0] pt, fk, ct, a5, m1;
    logic [255:0] k1;
    pt = 128'h3243f6a8885a308d313198a2e0370734;
    fk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct = 128'h3925841d02dc09fbdc118597196a0b32;
    a5 = {4{32'ha5a5a5a5}};
    rst = 1'b1; start = 1'b0; mode_r = 1'b0; somi = 1'b0; sel = 1'b0;
    msg_r = '0; key_r = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 256'(busy_o), 256'(1'b0));
    chk("reset_done", 256'(done_o), 256'(1'b0));
    chk("reset_result", 256'(result_o), 256'(0));
    chk("reset_simo", 256'(simo_o), 256'(1'b0));
    chk("reset_mode", 256'(mode_o), 256'(1'b0));
`ifdef AES_SPI_CS_EN
    chk("reset_cs", 256'(cs_o), 256'(1'b1));
`endif
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 known answer from the slave model
    txn(pt, {128'd0, fk}, 1'b0, 1'b0, ct, 0, -1, 1'b0);
    // Bit ordering: fixed pattern, then echo of the captured block
    txn(rand128(), {rand128(), rand128()}, 1'b1, 1'b0, a5, 0, -1, 1'b0);
    txn(rand128(), {rand128(), rand128()}, 1'b0, 1'b1, '0, 0, -1, 1'b0);
    // Start/inputs changing while busy are ignored
    txn(rand128(), {rand128(), rand128()}, 1'b1, 1'b1, '0, 50, -1, 1'b0);
    // Reset in the middle of RECV, then a clean transaction
    txn(rand128(), {rand128(), rand128()}, 1'b1, 1'b1, '0, 0, 60, 1'b0);
    txn(rand128(), {rand128(), rand128()}, 1'b0, 1'b0, rand128(), 0, -1, 1'b0);
    // Back-to-back with start held through done
    m1 = rand128(); k1 = {rand128(), rand128()};
    txn(m1, k1, 1'b0, 1'b1, '0, 0, -1, 1'b1);
    txn(~m1, ~k1, 1'b1, 1'b1, '0, 0, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      txn(rand128(), {rand128(), rand128()}, 1'($urandom), 1'($urandom), rand128(), 0, -1, 1'b0);
    end
    // 256-bit key instance
    sel = 1'b1;
    @(negedge clk);
    txn(rand128(), {rand128(), rand128()}, 1'b1, 1'b0, rand128(), 0, -1, 1'b0);
    txn(rand128(), {rand128(), rand128()}, 1'b0, 1'b1, '0, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
